// File: rtl/reg_write_sequencer_pkg.sv
// Shared constants and types for the register writeback path.
// NUM_REGS / ADDR_W are shared with the write decoder and the register file.
// The sequencer FSM state type lives here so checkers can bind to it.
package reg_write_sequencer_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/reg_write_sequencer_lowest_set_encoder.sv
// lowest_set_encoder: purely combinational one-hot/bitmap to binary encoder.
// Reports the index of the lowest set bit of the input bitmap.
// Ports:
//   bits  - input bitmap (NUM_REGS bits)
//   index - index of the lowest set bit; 0 when no bit is set
//   any   - high when at least one bit is set
module lowest_set_encoder #(
  parameter int NUM_REGS = reg_write_sequencer_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_write_sequencer_pkg::ADDR_W
) (
  input  logic [NUM_REGS-1:0] bits,
  output logic [ADDR_W-1:0]   index,
  output logic                any
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    index = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (bits[i]) index = ADDR_W'(i);
    end
  end

  assign any = |bits;

endmodule

// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer: serialises a bitmap of registers pending writeback
// into (RegWrite, WriteReg) pairs, lowest index first, one per accepted cycle.
//
// Handshakes (valid/ready): a request transfers on a rising edge where
// req_valid && req_ready; a write transfers on a rising edge where
// RegWrite && wb_ready. A holder of valid keeps its payload stable until the
// transfer; while RegWrite waits on wb_ready, WriteReg does not change.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid, req_mask - incoming bitmap (bit i = register i)
//   req_ready           - sequencer idle and not being flushed
//   flush               - abandon the current sequence (no done pulse)
//   wb_ready            - write port accepts the current write
//   RegWrite, WriteReg  - write request and register index
//   busy                - sequence in progress
//   done                - one-cycle pulse after a sequence completes
//
// All outputs except req_ready decode registered state only; req_ready
// additionally gates on flush so a flushing cycle never accepts a request.
module reg_write_sequencer
  import reg_write_sequencer_pkg::*;
#(
  parameter int NUM_REGS = reg_write_sequencer_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_write_sequencer_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [NUM_REGS-1:0] req_mask,
  output logic                req_ready,
  input  logic                flush,
  input  logic                wb_ready,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteReg,
  output logic                busy,
  output logic                done
);

  seq_state_e          state_q, state_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   low_index;
  logic                low_any;

  lowest_set_encoder #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_encoder (
    .bits  (pending_q),
    .index (low_index),
    .any   (low_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pending_d = req_mask;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          // A write accepted this same cycle still counts as issued.
          pending_d = '0;
          state_d   = IDLE;
        end else if (!low_any) begin
          // Empty mask: one busy cycle, then complete.
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (wb_ready) begin
          // x & (x-1) clears exactly the lowest set bit.
          pending_d = pending_q & (pending_q - NUM_REGS'(1));
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE) && !flush;
  assign busy      = (state_q == RUN);
  assign RegWrite  = (state_q == RUN) && low_any;
  assign WriteReg  = low_index;
  assign done      = done_q;

endmodule
